max_pool_2x2_stride_2: RTL and testbench

Downstream stage of the 3x3 stride-1 convolution kernel. It consumes that kernel's raster-order Data_Out/Valid_Out pixel stream and performs 2x2 max pooling with stride 2 on IEEE-754 single-precision values. It emits one pooled pixel per 2x2 window, also in raster order. The block holds one half-width line buffer of horizontal pair maxima, so there is no backpressure: every valid input is accepted.

---
 rtl/max_pool_2x2_stride_2_if.sv | 20 ++
 rtl/max_pool_2x2_stride_2.sv | 83 ++++++++
 tb/tb_max_pool_2x2_stride_2.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/max_pool_2x2_stride_2_if.sv
// rtl/max_pool_2x2_stride_2_if.sv - pixel stream in/out bundle for the 2x2 max-pool stage
interface max_pool_2x2_stride_2_if #(
  parameter int DATA_WIDHT = 32
);
  logic [DATA_WIDHT-1:0] Data_In;
  logic                  Valid_in;
  logic [DATA_WIDHT-1:0] Data_Out;
  logic                  Valid_Out;
  logic                  Frame_Done;

  modport master (
    output Data_In, Valid_in,
    input  Data_Out, Valid_Out, Frame_Done
  );

  modport slave (
    input  Data_In, Valid_in,
    output Data_Out, Valid_Out, Frame_Done
  );
endinterface

// File: rtl/max_pool_2x2_stride_2.sv
// rtl/max_pool_2x2_stride_2.sv - 2x2 stride-2 max pooling over a raster IEEE-754 pixel stream
// Horizontal pair maxima of even rows are parked in a half-width line buffer and folded in on odd rows.
module max_pool_2x2_stride_2 #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 218,
  parameter int IMG_HEIGHT = 218
) (
  input logic                     clk,
  input logic                     rst,
  max_pool_2x2_stride_2_if.slave  bus
);
  localparam int MSB    = DATA_WIDHT - 1;
  localparam int HALF_W = IMG_WIDHT / 2;
  localparam int CW     = (IMG_WIDHT > 1) ? $clog2(IMG_WIDHT) : 1;
  localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [MSB:0]    hold;
  logic [MSB:0]    linebuf [HALF_W];
  logic [LW-1:0]   idx;
  logic            last_col;
  logic            last_row;
  logic            wr_en;
  logic            emit;
  logic [MSB:0]    pair_max;
  logic [MSB:0]    win_max;

  // Sign-magnitude to monotonic unsigned: negatives are inverted, positives get the MSB set.
  function automatic logic [MSB:0] order_key(input logic [MSB:0] x);
    return x[MSB] ? ~x : {1'b1, x[MSB-1:0]};
  endfunction

  // The newer operand wins only on a strictly larger key, so ties keep the older one.
  function automatic logic [MSB:0] pick_max(input logic [MSB:0] older, input logic [MSB:0] newer);
    return (order_key(newer) > order_key(older)) ? newer : older;
  endfunction

  assign last_col = (col == CW'(IMG_WIDHT - 1));
  assign last_row = (row == RW'(IMG_HEIGHT - 1));
  assign idx      = LW'(col >> 1);
  assign pair_max = pick_max(hold, bus.Data_In);
  assign win_max  = pick_max(linebuf[idx], pair_max);

  // An odd column always has its even partner; an even last row only exists for odd heights and is dropped.
  assign wr_en = bus.Valid_in && col[0] && !row[0] && !last_row;
  assign emit  = bus.Valid_in && col[0] && row[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col            <= '0;
      row            <= '0;
      hold           <= '0;
      bus.Data_Out   <= '0;
      bus.Valid_Out  <= 1'b0;
      bus.Frame_Done <= 1'b0;
    end else begin
      bus.Valid_Out  <= emit;
      bus.Frame_Done <= bus.Valid_in && last_col && last_row;
      if (emit) begin
        bus.Data_Out <= win_max;
      end
      if (bus.Valid_in) begin
        if (!col[0]) begin
          hold <= bus.Data_In;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      linebuf[idx] <= pair_max;
    end
  end
endmodule

// File: tb/tb_max_pool_2x2_stride_2.sv
// tb/tb_max_pool_2x2_stride_2.sv - self-checking bench for the 2x2 stride-2 max-pool stage
module tb_max_pool_2x2_stride_2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  max_pool_2x2_stride_2_if #(.DATA_WIDHT(32)) bus4 ();
  max_pool_2x2_stride_2_if #(.DATA_WIDHT(32)) bus5 ();

  max_pool_2x2_stride_2 #(.DATA_WIDHT(32), .IMG_WIDHT(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );
  max_pool_2x2_stride_2 #(.DATA_WIDHT(32), .IMG_WIDHT(5), .IMG_HEIGHT(5)) dut5 (
    .clk(clk), .rst(rst), .bus(bus5.slave)
  );

  logic [31:0] din  = '0;
  logic        vin4 = 1'b0;
  logic        vin5 = 1'b0;
  assign bus4.Data_In  = din;
  assign bus4.Valid_in = vin4;
  assign bus5.Data_In  = din;
  assign bus5.Valid_in = vin5;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] pix [75];
  logic [31:0] outs [$];
  int          fd_count;
  logic [31:0] last4 = '0;
  logic [31:0] last5 = '0;

  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return (fkey(b) > fkey(a)) ? b : a;
  endfunction

  // Exact single-precision encoding of a small non-negative integer.
  function automatic logic [31:0] itof(input int n);
    int e;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 24; i++) if ((n >> i) & 1) e = i;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic stream(input int w, input int h, input int nf, input int gap_pct, input string tag);
    int total, idx, p, r, c, base, bound, idle_left;
    bit acc, long_done;
    logic ev, efd, ov, ofd;
    logic [31:0] ed, od;
    total = w * h * nf;
    idx = 0; bound = 0; idle_left = 0; long_done = 0;
    ed = (w == 5) ? last5 : last4;
    outs.delete();
    fd_count = 0;
    while (bound < 3000) begin
      bound++;
      acc = 0;
      if (idx < total) begin
        if (gap_pct > 0 && !long_done && idx == total / 2) begin
          idle_left = 12;
          long_done = 1;
        end
        if (idle_left > 0) idle_left--;
        else acc = ($urandom_range(99) >= gap_pct);
      end
      din = acc ? pix[idx] : $urandom;
      if (w == 5) vin5 = acc; else vin4 = acc;
      ev = 0;
      efd = 0;
      if (acc) begin
        p = idx % (w * h);
        base = idx - p;
        r = p / w;
        c = p % w;
        if (r % 2 == 1 && c % 2 == 1 && r / 2 < h / 2 && c / 2 < w / 2) begin
          ev = 1;
          ed = fmax(fmax(fmax(pix[base + (r-1)*w + c-1], pix[base + (r-1)*w + c]),
                         pix[base + r*w + c-1]), pix[base + r*w + c]);
        end
        efd = (p == w * h - 1);
        idx++;
      end
      @(negedge clk);
      ov  = (w == 5) ? bus5.Valid_Out  : bus4.Valid_Out;
      od  = (w == 5) ? bus5.Data_Out   : bus4.Data_Out;
      ofd = (w == 5) ? bus5.Frame_Done : bus4.Frame_Done;
      n_assert += 3;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL %s valid_out idx=%0d got=%b exp=%b", tag, idx, ov, ev);
      end
      if (od !== ed) begin
        n_fail++;
        $display("FAIL %s data_out idx=%0d got=%h exp=%h", tag, idx, od, ed);
      end
      if (ofd !== efd) begin
        n_fail++;
        $display("FAIL %s frame_done idx=%0d got=%b exp=%b", tag, idx, ofd, efd);
      end
      if (ov === 1'b1) outs.push_back(od);
      if (ofd === 1'b1) fd_count++;
      if (idx == total && !acc) break;
    end
    n_assert++;
    if (idx != total || bound >= 3000) begin
      n_fail++;
      $display("FAIL %s timeout accepted=%0d exp=%0d", tag, idx, total);
    end
    vin4 = 1'b0;
    vin5 = 1'b0;
    if (w == 5) last5 = ed; else last4 = ed;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    n_assert++;
    if (outs.size() != 4) begin
      n_fail++;
      $display("FAIL %s out_count got=%0d exp=4", tag, outs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_assert++;
        if (outs[i] !== ex[i]) begin
          n_fail++;
          $display("FAIL %s out[%0d] got=%h exp=%h", tag, i, outs[i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vin4 = 1'b0;
    vin5 = 1'b0;
    repeat (2) @(negedge clk);
    n_assert += 6;
    if (bus4.Valid_Out !== 1'b0 || bus4.Data_Out !== 32'h0 || bus4.Frame_Done !== 1'b0) begin
      n_fail += 3;
      $display("FAIL reset dut4 got v=%b d=%h fd=%b exp 0", bus4.Valid_Out, bus4.Data_Out, bus4.Frame_Done);
    end
    if (bus5.Valid_Out !== 1'b0 || bus5.Data_Out !== 32'h0 || bus5.Frame_Done !== 1'b0) begin
      n_fail += 3;
      $display("FAIL reset dut5 got v=%b d=%h fd=%b exp 0", bus5.Valid_Out, bus5.Data_Out, bus5.Frame_Done);
    end
    rst = 1'b0;
    last4 = '0;
    last5 = '0;
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 16; i++) pix[i] = itof(i);
    stream(4, 4, 1, 0, "ramp");
    check_outs("ramp", 32'h40A00000, 32'h40E00000, 32'h41500000, 32'h41700000);
    n_assert++;
    if (fd_count != 1) begin
      n_fail++;
      $display("FAIL ramp frame_done_count got=%0d exp=1", fd_count);
    end
  endtask

  task automatic test_negative();
    for (int i = 0; i < 16; i++) pix[i] = $urandom;
    pix[0] = 32'hBF800000; pix[1] = 32'hC0000000; pix[4] = 32'hBF000000; pix[5] = 32'hC0400000;
    pix[2] = 32'h80000000; pix[3] = 32'h00000000; pix[6] = 32'hBF800000; pix[7] = 32'hC0000000;
    stream(4, 4, 1, 0, "negative");
    n_assert += 2;
    if (outs.size() < 2 || outs[0] !== 32'hBF000000 || outs[1] !== 32'h00000000) begin
      n_fail += 2;
      $display("FAIL negative windows got n=%0d w0=%h w1=%h exp BF000000 00000000",
               outs.size(), (outs.size() > 0) ? outs[0] : 32'hx, (outs.size() > 1) ? outs[1] : 32'hx);
    end
  endtask

  task automatic test_odd_dims();
    for (int i = 0; i < 25; i++) pix[i] = itof(i);
    stream(5, 5, 1, 0, "odd_dims");
    check_outs("odd_dims", 32'h40C00000, 32'h41000000, 32'h41800000, 32'h41900000);
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 16; i++) pix[i] = itof(i);
    stream(4, 4, 1, 50, "gaps");
    check_outs("gaps", 32'h40A00000, 32'h40E00000, 32'h41500000, 32'h41700000);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 75; i++) pix[i] = $urandom;
      stream(4, 4, 3, 30, "random4");
      for (int i = 0; i < 25; i++) pix[i] = $urandom;
      stream(5, 5, 1, 30, "random5");
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) pix[i] = itof(i);
    for (int i = 0; i < 6; i++) begin
      din = pix[i];
      vin4 = 1'b1;
      @(negedge clk);
    end
    vin4 = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_assert += 3;
    if (bus4.Valid_Out !== 1'b0 || bus4.Data_Out !== 32'h0 || bus4.Frame_Done !== 1'b0) begin
      n_fail += 3;
      $display("FAIL reset_mid async got v=%b d=%h fd=%b exp 0", bus4.Valid_Out, bus4.Data_Out, bus4.Frame_Done);
    end
    repeat (2) @(negedge clk);
    n_assert++;
    if (bus4.Valid_Out !== 1'b0 || bus4.Data_Out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid held got v=%b d=%h exp 0", bus4.Valid_Out, bus4.Data_Out);
    end
    rst = 1'b0;
    last4 = '0;
    last5 = '0;
    stream(4, 4, 1, 0, "reset_mid");
    check_outs("reset_mid", 32'h40A00000, 32'h40E00000, 32'h41500000, 32'h41700000);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      pix[i]      = itof(i);
      pix[16 + i] = itof(i + 100);
      pix[32 + i] = itof(i) | 32'h8000_0000;
    end
    stream(4, 4, 3, 0, "back_to_back");
    n_assert += 2;
    if (fd_count != 3) begin
      n_fail++;
      $display("FAIL back_to_back frame_done_count got=%0d exp=3", fd_count);
    end
    if (outs.size() != 12) begin
      n_fail++;
      $display("FAIL back_to_back out_count got=%0d exp=12", outs.size());
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_odd_dims();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
